// File: rtl/softmax_pkg.sv
// softmax_pkg: shared constants and types for the softmax block family.
//   - DATAWIDTH / NUM / ADDRSIZE: default element width, lanes per word,
//     RAM address width.
//   - FP16_NEG_INF / FP16_ZERO: fp16 constants.
//   - FP16_PAD: value written into unfilled lanes of a frame's final word.
//     It is -inf when SOFTMAX_LOADER_PAD_EN is defined, so padding
//     contributes exp()=0 to the sum. Otherwise it is +0.
//   - ld_state_e: input loader FSM states.
package softmax_pkg;
  localparam int DATAWIDTH = 16;
  localparam int NUM       = 4;
  localparam int ADDRSIZE  = 16;

  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

`ifdef SOFTMAX_LOADER_PAD_EN
  localparam logic [15:0] FP16_PAD = FP16_NEG_INF;
`else
  localparam logic [15:0] FP16_PAD = FP16_ZERO;
`endif

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WRITE = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/softmax_lane_packer.sv
// softmax_lane_packer: gathers accepted elements into a NUM-lane word.
//   clk, reset_n   : clock and asynchronous active-low reset
//   acc            : an element is accepted this cycle
//   in_data/in_last: the accepted element and its end-of-frame flag
//   clr            : force the lane counter back to lane 0
//   word_done      : the accept completes a word (full lane, or last element)
//   word_last      : the accept carries in_last
//   word           : the completed word, valid with word_done. It includes
//                    the current element, and lanes above it are padded
//                    when the element is last.
// The pad value depends on SOFTMAX_LOADER_PAD_EN (see softmax_pkg).
module softmax_lane_packer
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH = softmax_pkg::DATAWIDTH,
  parameter int NUM       = softmax_pkg::NUM,
  localparam int LW       = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           acc,
  input  logic [DATAWIDTH-1:0]           in_data,
  input  logic                           in_last,
  input  logic                           clr,
  output logic                           word_done,
  output logic                           word_last,
  output logic [NUM-1:0][DATAWIDTH-1:0]  word
);
  logic [LW-1:0]                 lane_q, lane_d;
  logic [NUM-1:0][DATAWIDTH-1:0] lanes_q, lanes_d;
  logic                          full;

  always_comb begin
    lanes_d   = lanes_q;
    lane_d    = lane_q;
    word      = lanes_q;
    word_done = 1'b0;
    word_last = 1'b0;
    full      = (lane_q == LW'(NUM - 1));
    if (acc) begin
      lanes_d[lane_q] = in_data;
      // The word is emitted combinationally, so the current element bypasses the register.
      word[lane_q]    = in_data;
      word_last       = in_last;
      if (in_last) begin
        for (int l = 0; l < NUM; l++) begin
          if (LW'(l) > lane_q) word[l] = DATAWIDTH'(FP16_PAD);
        end
      end
      word_done = in_last | full;
      lane_d    = word_done ? '0 : lane_q + 1'b1;
    end
    if (clr) lane_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q  <= '0;
      lanes_q <= '0;
    end else begin
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
    end
  end
endmodule

// File: rtl/softmax_in_loader.sv
// softmax_in_loader: upstream loader for the softmax block.
// It packs a stream of fp16 scores NUM-wide. The words are written at
// consecutive addresses from 0 through one broadcast RAM write port. After
// the final word of the frame, the loader publishes addr_limit, pulses
// start, and waits for done before it accepts the next frame.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   in_data/in_valid/in_last      : element stream in
//   in_ready                      : element accepted when in_valid && in_ready
//   mem_we/mem_addr/mem_wdata     : RAM write port (lane 0 in the LSBs)
//   addr_limit                    : last word address written (inclusive)
//   start                         : one-cycle launch pulse
//   done                          : softmax completion, sampled in WAIT only
//   busy                          : frame handed off, waiting for done
//   overflow                      : sticky; a frame ran out of address space
// The pad value is selected with SOFTMAX_LOADER_PAD_EN (see softmax_pkg).
module softmax_in_loader
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH = softmax_pkg::DATAWIDTH,
  parameter int NUM       = softmax_pkg::NUM,
  parameter int ADDRSIZE  = softmax_pkg::ADDRSIZE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATAWIDTH-1:0]     in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRSIZE-1:0]      mem_addr,
  output logic [DATAWIDTH*NUM-1:0] mem_wdata,
  output logic [ADDRSIZE-1:0]      addr_limit,
  output logic                     start,
  input  logic                     done,
  output logic                     busy,
  output logic                     overflow
);
  localparam logic [ADDRSIZE-1:0] ADDR_MAX = '1;

  ld_state_e                     state_q, state_d;
  logic [ADDRSIZE-1:0]           wr_addr_q, wr_addr_d;
  logic [ADDRSIZE-1:0]           mem_addr_q, mem_addr_d;
  logic [NUM-1:0][DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDRSIZE-1:0]           addr_limit_q, addr_limit_d;
  logic mem_we_q, mem_we_d;
  logic start_q, start_d;
  logic busy_q, busy_d;
  logic in_ready_q, in_ready_d;
  logic overflow_q, overflow_d;

  logic                          acc, clr, word_done, word_last;
  logic [NUM-1:0][DATAWIDTH-1:0] word;

  assign acc = in_valid & in_ready_q & (state_q == FILL);

  softmax_lane_packer #(
    .DATAWIDTH (DATAWIDTH),
    .NUM       (NUM)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .acc       (acc),
    .in_data   (in_data),
    .in_last   (in_last),
    .clr       (clr),
    .word_done (word_done),
    .word_last (word_last),
    .word      (word)
  );

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    addr_limit_d = addr_limit_q;
    overflow_d   = overflow_q;
    mem_we_d     = 1'b0;
    clr          = 1'b0;
    case (state_q)
      FILL: begin
        if (word_done) begin
          // Every completed word is registered into the write port. The final
          // word's write cycle is the WRITE state.
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = word;
          if (word_last) begin
            state_d = WRITE;
          end else if (wr_addr_q == ADDR_MAX) begin
            // Out of address space: launch what we have.
            state_d    = WRITE;
            overflow_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      WRITE: begin
        state_d      = START;
        addr_limit_d = mem_addr_q;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (done) begin
          state_d   = FILL;
          wr_addr_d = '0;
          clr       = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    // Control outputs are registered from the next state, so they are 0 in reset.
    in_ready_d = (state_d == FILL);
    start_d    = (state_d == START);
    busy_d     = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      wr_addr_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      addr_limit_q <= '0;
      mem_we_q     <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      addr_limit_q <= addr_limit_d;
      mem_we_q     <= mem_we_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign addr_limit = addr_limit_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_softmax_in_loader.sv
// tb_softmax_in_loader: directed bench for softmax_in_loader.
// Instance "a" uses default parameters. Instance "b" uses ADDRSIZE=2 for
// the overflow case. sel_b steers the shared stream to one instance.
module tb_softmax_in_loader;
`ifdef SOFTMAX_LOADER_PAD_EN
  localparam logic [15:0] PAD = 16'hFC00;
`else
  localparam logic [15:0] PAD = 16'h0000;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, done = 1'b0, sel_b = 1'b0;
  always #5 clk = ~clk;

  logic va, vb, da, db;
  assign va = in_valid & ~sel_b;
  assign vb = in_valid & sel_b;
  assign da = done & ~sel_b;
  assign db = done & sel_b;

  logic        rdy_a, we_a, start_a, busy_a, ovf_a;
  logic [15:0] addr_a, lim_a;
  logic [63:0] wdata_a;
  logic        rdy_b, we_b, start_b, busy_b, ovf_b;
  logic [1:0]  addr_b, lim_b;
  logic [63:0] wdata_b;

  softmax_in_loader u_a (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(va), .in_last(in_last),
    .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .addr_limit(lim_a), .start(start_a), .done(da), .busy(busy_a), .overflow(ovf_a)
  );

  softmax_in_loader #(.ADDRSIZE(2)) u_b (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(vb), .in_last(in_last),
    .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .addr_limit(lim_b), .start(start_b), .done(db), .busy(busy_b), .overflow(ovf_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wa_addr[$], wb_addr[$];
  logic [63:0] wa_data[$], wb_data[$];
  int st_a = 0, st_cyc_a = -1, st_b = 0;
  always @(negedge clk) begin
    if (we_a) begin wa_addr.push_back(addr_a); wa_data.push_back(wdata_a); end
    if (we_b) begin wb_addr.push_back(16'(addr_b)); wb_data.push_back(wdata_b); end
    if (start_a) begin st_a <= st_a + 1; st_cyc_a <= cyc; end
    if (start_b) st_b <= st_b + 1;
  end

  int n_chk = 0, n_fail = 0, last_c = 0, s0 = 0;
  logic [63:0] e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_rdy();  return sel_b ? rdy_b : rdy_a;   endfunction
  function automatic logic cur_busy(); return sel_b ? busy_b : busy_a; endfunction

  // Drive one element at a negedge once in_ready is seen high. The element
  // is accepted at the next rising edge.
  task automatic send(input logic [15:0] d, input logic l);
    int k = 0;
    @(negedge clk);
    while (!cur_rdy() && k < 200) begin
      in_valid = 1'b0; k++; @(negedge clk);
    end
    if (k >= 200) chk("send_ready", {63'd0, cur_rdy()}, 64'd1);
    in_valid = 1'b1; in_data = d; in_last = l; last_c = cyc;
  endtask

  task automatic idle();
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int k = 0;
    while (!cur_busy() && k < 100) begin @(negedge clk); k++; end
    chk(tag, {63'd0, cur_busy()}, 64'd1);
  endtask

  task automatic pulse_done(input string tag);
    @(negedge clk);
    chk({tag, "_rdy_wait"}, {63'd0, cur_rdy()}, 64'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk({tag, "_rdy_after_done"}, {63'd0, cur_rdy()}, 64'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rdy", {63'd0, rdy_a}, 64'd0);
    chk("rst_we", {63'd0, we_a}, 64'd0);
    chk("rst_start", {63'd0, start_a}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_ovf", {62'd0, ovf_a, ovf_b}, 64'd0);
    chk("rst_addr", {32'd0, addr_a, lim_a}, 64'd0);
    chk("rst_wdata", wdata_a, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {63'd0, rdy_a}, 64'd1);

    // Single word
    send(16'h3800, 0); send(16'h4040, 0); send(16'h4210, 0); send(16'h993E, 1);
    idle();
    wait_busy("t1_busy");
    chk("t1_nwr", 64'(wa_addr.size()), 64'd1);
    chk("t1_addr", 64'(wa_addr[0]), 64'd0);
    chk("t1_data", wa_data[0], 64'h993E_4210_4040_3800);
    chk("t1_start_lat", 64'(st_cyc_a - last_c), 64'd2);
    chk("t1_nstart", 64'(st_a), 64'd1);
    chk("t1_limit", 64'(lim_a), 64'd0);
    // Keep done low for 50 cycles with data offered; nothing may be accepted.
    repeat (50) begin @(negedge clk); in_valid = 1'b1; in_data = 16'h1234; end
    in_valid = 1'b0;
    chk("t1_hold_nwr", 64'(wa_addr.size()), 64'd1);
    chk("t1_hold_busy", {63'd0, busy_a}, 64'd1);
    pulse_done("t1");

    // Partial word with padding
    wa_addr.delete(); wa_data.delete();
    for (int i = 0; i < 6; i++) send(16'h3C00, i == 5);
    idle();
    wait_busy("t2_busy");
    chk("t2_nwr", 64'(wa_addr.size()), 64'd2);
    chk("t2_addr0", 64'(wa_addr[0]), 64'd0);
    chk("t2_data0", wa_data[0], 64'h3C00_3C00_3C00_3C00);
    chk("t2_addr1", 64'(wa_addr[1]), 64'd1);
    chk("t2_data1", wa_data[1], {PAD, PAD, 16'h3C00, 16'h3C00});
    chk("t2_limit", 64'(lim_a), 64'd1);
    pulse_done("t2");

    // Handshake: in_valid toggled every other cycle
    wa_addr.delete(); wa_data.delete();
    for (int i = 0; i < 20; i++) begin
      send(16'(16'h1000 + i), i == 19);
      idle();
    end
    wait_busy("t3_busy");
    chk("t3_nwr", 64'(wa_addr.size()), 64'd5);
    for (int w = 0; w < 5; w++) begin
      e = {16'(16'h1000 + 4*w + 3), 16'(16'h1000 + 4*w + 2),
           16'(16'h1000 + 4*w + 1), 16'(16'h1000 + 4*w)};
      if (wa_addr.size() > w) begin
        chk($sformatf("t3_addr%0d", w), 64'(wa_addr[w]), 64'(w));
        chk($sformatf("t3_data%0d", w), wa_data[w], e);
      end
    end
    chk("t3_limit", 64'(lim_a), 64'd4);
    pulse_done("t3");

    // Single-element frame
    wa_addr.delete(); wa_data.delete();
    send(16'h4000, 1);
    idle();
    wait_busy("t4_busy");
    chk("t4_nwr", 64'(wa_addr.size()), 64'd1);
    chk("t4_addr", 64'(wa_addr[0]), 64'd0);
    chk("t4_data", wa_data[0], {PAD, PAD, PAD, 16'h4000});
    chk("t4_limit", 64'(lim_a), 64'd0);
    pulse_done("t4");

    // Reset mid-frame
    s0 = st_a;
    wa_addr.delete(); wa_data.delete();
    send(16'h5000, 0); send(16'h5001, 0); send(16'h5002, 0);
    @(negedge clk); in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_rdy", {63'd0, rdy_a}, 64'd0);
    chk("t5_rst_wdata", wdata_a, 64'd0);
    chk("t5_rst_misc", {60'd0, we_a, start_a, busy_a, ovf_a}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    send(16'h6000, 0); send(16'h6001, 0); send(16'h6002, 0); send(16'h6003, 1);
    idle();
    wait_busy("t5_busy");
    chk("t5_nwr", 64'(wa_addr.size()), 64'd1);
    chk("t5_addr", 64'(wa_addr[0]), 64'd0);
    chk("t5_data", wa_data[0], 64'h6003_6002_6001_6000);
    chk("t5_nstart", 64'(st_a - s0), 64'd1);
    pulse_done("t5");

    // Overflow on the ADDRSIZE=2 instance
    @(negedge clk); sel_b = 1'b1;
    for (int i = 0; i < 16; i++) send(16'(16'h2000 + i), 0);
    idle();
    wait_busy("t6_busy");
    chk("t6_ovf", {63'd0, ovf_b}, 64'd1);
    chk("t6_limit", 64'(lim_b), 64'd3);
    chk("t6_nstart", 64'(st_b), 64'd1);
    chk("t6_nwr", 64'(wb_addr.size()), 64'd4);
    for (int w = 0; w < 4; w++) begin
      e = {16'(16'h2000 + 4*w + 3), 16'(16'h2000 + 4*w + 2),
           16'(16'h2000 + 4*w + 1), 16'(16'h2000 + 4*w)};
      if (wb_addr.size() > w) begin
        chk($sformatf("t6_addr%0d", w), 64'(wb_addr[w]), 64'(w));
        chk($sformatf("t6_data%0d", w), wb_data[w], e);
      end
    end
    pulse_done("t6");
    for (int i = 16; i < 20; i++) send(16'(16'h2000 + i), 0);
    idle(); idle(); idle();
    chk("t6_nwr2", 64'(wb_addr.size()), 64'd5);
    if (wb_addr.size() > 4) begin
      chk("t6_addr_wrap", 64'(wb_addr[4]), 64'd0);
      chk("t6_data_wrap", wb_data[4], 64'h2013_2012_2011_2010);
    end
    chk("t6_ovf_sticky", {63'd0, ovf_b}, 64'd1);
    chk("t6_nstart2", 64'(st_b), 64'd1);
    chk("t6_busy2", {63'd0, busy_b}, 64'd0);
    chk("t6_a_ovf", {63'd0, ovf_a}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
